// File: rtl/model_matrix_integer_divider_iterative_if.sv
// rtl/model_matrix_integer_divider_iterative_if.sv - operand/result bundle for the element-wise matrix divider.
// master drives sizes, operands and enables; slave is the divider.
interface model_matrix_integer_divider_iterative_if #(
    parameter int DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic                 SIGNED_MODE;
    logic                 DATA_A_IN_I_ENABLE;
    logic                 DATA_A_IN_J_ENABLE;
    logic                 DATA_B_IN_I_ENABLE;
    logic                 DATA_B_IN_J_ENABLE;
    logic                 DATA_OUT_I_ENABLE;
    logic                 DATA_OUT_J_ENABLE;
    logic                 DIV_BY_ZERO;
    logic [DATA_SIZE-1:0] SIZE_I_IN;
    logic [DATA_SIZE-1:0] SIZE_J_IN;
    logic [DATA_SIZE-1:0] DATA_A_IN;
    logic [DATA_SIZE-1:0] DATA_B_IN;
    logic [DATA_SIZE-1:0] DATA_OUT;
    logic [DATA_SIZE-1:0] REST_OUT;

    modport master (
        output START, SIGNED_MODE,
        output DATA_A_IN_I_ENABLE, DATA_A_IN_J_ENABLE,
        output DATA_B_IN_I_ENABLE, DATA_B_IN_J_ENABLE,
        output SIZE_I_IN, SIZE_J_IN, DATA_A_IN, DATA_B_IN,
        input  READY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DIV_BY_ZERO,
        input  DATA_OUT, REST_OUT
    );

    modport slave (
        input  START, SIGNED_MODE,
        input  DATA_A_IN_I_ENABLE, DATA_A_IN_J_ENABLE,
        input  DATA_B_IN_I_ENABLE, DATA_B_IN_J_ENABLE,
        input  SIZE_I_IN, SIZE_J_IN, DATA_A_IN, DATA_B_IN,
        output READY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DIV_BY_ZERO,
        output DATA_OUT, REST_OUT
    );
endinterface

// File: rtl/model_matrix_integer_divider_iterative.sv
// rtl/model_matrix_integer_divider_iterative.sv - element-wise matrix divider, radix-2 restoring, one quotient bit per cycle.
// Signed division is built only when MODEL_MATRIX_INTEGER_DIVIDER_SIGNED_EN is defined.
module model_matrix_integer_divider_iterative #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input logic                                     CLK,
    input logic                                     RST,
    model_matrix_integer_divider_iterative_if.slave bus
);

`ifdef MODEL_MATRIX_INTEGER_DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam int CW = $clog2(DATA_SIZE + 2);
    localparam int W  = (DATA_SIZE > CONTROL_SIZE) ? DATA_SIZE : CONTROL_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_J,
        DIVIDE,
        OUTPUT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_SIZE-1:0]  size_i_q, size_i_d;
    logic [DATA_SIZE-1:0]  size_j_q, size_j_d;
    logic [CONTROL_SIZE-1:0] i_q, i_d;
    logic [CONTROL_SIZE-1:0] j_q, j_d;
    logic [DATA_SIZE-1:0]  a_q, a_d;
    logic [DATA_SIZE-1:0]  b_q, b_d;
    logic                  a_vld_q, a_vld_d;
    logic                  b_vld_q, b_vld_d;
    logic [DATA_SIZE-1:0]  quo_q, quo_d;
    logic [DATA_SIZE-1:0]  rem_q, rem_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  signed_q, signed_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [DATA_SIZE-1:0]  data_out_q, data_out_d;
    logic [DATA_SIZE-1:0]  rest_out_q, rest_out_d;
    logic                  out_j_en_q, out_j_en_d;
    logic                  out_i_en_q, out_i_en_d;
    logic                  ready_q, ready_d;
    logic                  dbz_q, dbz_d;

    logic                  a_en;
    logic                  b_en;
    logic                  neg_a;
    logic                  neg_b;
    logic                  i_last;
    logic                  j_last;
    logic [DATA_SIZE:0]    shifted;
    logic [DATA_SIZE:0]    diff;

    assign a_en = (state_q == LOAD_I) ? bus.DATA_A_IN_I_ENABLE
                                      : ((state_q == LOAD_J) & bus.DATA_A_IN_J_ENABLE);
    assign b_en = (state_q == LOAD_I) ? bus.DATA_B_IN_I_ENABLE
                                      : ((state_q == LOAD_J) & bus.DATA_B_IN_J_ENABLE);

    assign neg_a = signed_q & a_q[DATA_SIZE-1];
    assign neg_b = signed_q & b_q[DATA_SIZE-1];

    // Sizes are never zero once a matrix is running, so size-1 cannot wrap.
    assign i_last = (W'(i_q) == (W'(size_i_q) - W'(1)));
    assign j_last = (W'(j_q) == (W'(size_j_q) - W'(1)));

    // Partial remainder is one bit wider than the operands; a set MSB of diff means "restore".
    assign shifted = {rem_q, quo_q[DATA_SIZE-1]};
    assign diff    = shifted - {1'b0, b_q};

    always_comb begin
        state_d    = state_q;
        size_i_d   = size_i_q;
        size_j_d   = size_j_q;
        i_d        = i_q;
        j_d        = j_q;
        a_d        = a_q;
        b_d        = b_q;
        a_vld_d    = a_vld_q;
        b_vld_d    = b_vld_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        signed_d   = signed_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        data_out_d = data_out_q;
        rest_out_d = rest_out_q;
        out_j_en_d = 1'b0;
        out_i_en_d = 1'b0;
        ready_d    = 1'b0;
        dbz_d      = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    size_i_d = bus.SIZE_I_IN;
                    size_j_d = bus.SIZE_J_IN;
                    signed_d = bus.SIGNED_MODE & SIGNED_EN;
                    dbz_d    = 1'b0;
                    i_d      = '0;
                    j_d      = '0;
                    if ((bus.SIZE_I_IN == '0) || (bus.SIZE_J_IN == '0)) begin
                        ready_d = 1'b1;
                    end else begin
                        state_d = LOAD_I;
                    end
                end
            end

            LOAD_I, LOAD_J: begin
                if (a_en) begin
                    a_d     = bus.DATA_A_IN;
                    a_vld_d = 1'b1;
                end
                if (b_en) begin
                    b_d     = bus.DATA_B_IN;
                    b_vld_d = 1'b1;
                end
                if (a_vld_d && b_vld_d) begin
                    a_vld_d = 1'b0;
                    b_vld_d = 1'b0;
                    cnt_d   = '0;
                    state_d = DIVIDE;
                end
            end

            DIVIDE: begin
                if (cnt_q == '0) begin
                    if (b_q == '0) begin
                        quo_d   = '1;
                        rem_d   = a_q;
                        dbz_d   = 1'b1;
                        state_d = OUTPUT;
                    end else begin
                        // Divide magnitudes; signs are restored in the fix-up step.
                        quo_d     = neg_a ? -a_q : a_q;
                        b_d       = neg_b ? -b_q : b_q;
                        neg_quo_d = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                        rem_d     = '0;
                        cnt_d     = CW'(1);
                    end
                end else if (cnt_q <= CW'(DATA_SIZE)) begin
                    if (diff[DATA_SIZE]) begin
                        rem_d = shifted[DATA_SIZE-1:0];
                        quo_d = {quo_q[DATA_SIZE-2:0], 1'b0};
                    end else begin
                        rem_d = diff[DATA_SIZE-1:0];
                        quo_d = {quo_q[DATA_SIZE-2:0], 1'b1};
                    end
                    if (cnt_q == CW'(DATA_SIZE)) begin
                        if (signed_q) begin
                            cnt_d = cnt_q + CW'(1);
                        end else begin
                            state_d = OUTPUT;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    if (neg_quo_q) begin
                        quo_d = -quo_q;
                    end
                    if (neg_rem_q) begin
                        rem_d = -rem_q;
                    end
                    state_d = OUTPUT;
                end
            end

            OUTPUT: begin
                data_out_d = quo_q;
                rest_out_d = rem_q;
                out_j_en_d = 1'b1;
                out_i_en_d = j_last;
                ready_d    = j_last & i_last;
                if (!j_last) begin
                    j_d     = j_q + CONTROL_SIZE'(1);
                    state_d = LOAD_J;
                end else if (!i_last) begin
                    j_d     = '0;
                    i_d     = i_q + CONTROL_SIZE'(1);
                    state_d = LOAD_I;
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            size_i_q   <= '0;
            size_j_q   <= '0;
            i_q        <= '0;
            j_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            a_vld_q    <= 1'b0;
            b_vld_q    <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            data_out_q <= '0;
            rest_out_q <= '0;
            out_j_en_q <= 1'b0;
            out_i_en_q <= 1'b0;
            ready_q    <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_i_q   <= size_i_d;
            size_j_q   <= size_j_d;
            i_q        <= i_d;
            j_q        <= j_d;
            a_q        <= a_d;
            b_q        <= b_d;
            a_vld_q    <= a_vld_d;
            b_vld_q    <= b_vld_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            signed_q   <= signed_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            data_out_q <= data_out_d;
            rest_out_q <= rest_out_d;
            out_j_en_q <= out_j_en_d;
            out_i_en_q <= out_i_en_d;
            ready_q    <= ready_d;
            dbz_q      <= dbz_d;
        end
    end

    assign bus.DATA_OUT          = data_out_q;
    assign bus.REST_OUT          = rest_out_q;
    assign bus.DATA_OUT_J_ENABLE = out_j_en_q;
    assign bus.DATA_OUT_I_ENABLE = out_i_en_q;
    assign bus.READY             = ready_q;
    assign bus.DIV_BY_ZERO       = dbz_q;

endmodule

// File: tb/tb_model_matrix_integer_divider_iterative.sv
// tb/tb_model_matrix_integer_divider_iterative.sv - vector table plus scoreboard bench for the matrix divider.
// Expected signed results follow MODEL_MATRIX_INTEGER_DIVIDER_SIGNED_EN.
module tb_model_matrix_integer_divider_iterative;
    localparam int DS = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    model_matrix_integer_divider_iterative_if #(.DATA_SIZE(DS)) bus ();

    model_matrix_integer_divider_iterative #(
        .DATA_SIZE   (DS),
        .CONTROL_SIZE(8)
    ) u_dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       ien;
        logic       rdy;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         gap;
        logic [7:0] q;
        logic [7:0] r;
        int         lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[18];

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int cap_cyc    = 0;
    int out_cnt    = 0;
    int ready_only = 0;
    int base_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial forever begin
        @(negedge CLK);
        chk("i_en_without_j", 32'(bus.DATA_OUT_I_ENABLE & ~bus.DATA_OUT_J_ENABLE), 0);
        if (bus.DATA_OUT_J_ENABLE) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", bus.DATA_OUT);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", bus.DATA_OUT, mon_e.q);
                chk("remainder", bus.REST_OUT, mon_e.r);
                chk("i_enable", bus.DATA_OUT_I_ENABLE, mon_e.ien);
                chk("ready", bus.READY, mon_e.rdy);
                chk("latency", cyc - cap_cyc, mon_e.lat);
            end
            out_cnt++;
        end else if (bus.READY) begin
            ready_only++;
        end
    end

    task automatic start_mat(input logic [7:0] si, input logic [7:0] sj, input logic sg);
        bus.SIZE_I_IN   = si;
        bus.SIZE_J_IN   = sj;
        bus.SIGNED_MODE = sg;
        bus.START       = 1'b1;
        tick(1);
        bus.START       = 1'b0;
        bus.SIZE_I_IN   = 8'hFF;
        bus.SIZE_J_IN   = 8'hFF;
        bus.SIGNED_MODE = ~sg;
    endtask

    task automatic feed(input int idx, input logic first, input logic ien, input logic rdy);
        vec_t v;
        exp_t e;
        v = vt[idx];
        e.q = v.q; e.r = v.r; e.ien = ien; e.rdy = rdy; e.lat = v.lat;
        sb.push_back(e);
        bus.DATA_A_IN = v.a;
        bus.DATA_A_IN_I_ENABLE = first;
        bus.DATA_A_IN_J_ENABLE = ~first;
        if (v.gap > 0) begin
            tick(1);
            bus.DATA_A_IN_I_ENABLE = 1'b0;
            bus.DATA_A_IN_J_ENABLE = 1'b0;
            bus.DATA_A_IN          = 8'h5A;
            if (v.gap > 1) tick(v.gap - 1);
        end
        bus.DATA_B_IN = v.b;
        bus.DATA_B_IN_I_ENABLE = first;
        bus.DATA_B_IN_J_ENABLE = ~first;
        tick(1);
        cap_cyc = cyc;
        bus.DATA_A_IN_I_ENABLE = 1'b0;
        bus.DATA_A_IN_J_ENABLE = 1'b0;
        bus.DATA_B_IN_I_ENABLE = 1'b0;
        bus.DATA_B_IN_J_ENABLE = 1'b0;
        bus.DATA_A_IN          = 8'hA5;
        bus.DATA_B_IN          = 8'hC3;
    endtask

    task automatic wait_out(input int target);
        for (int k = 0; k < 60 && out_cnt < target; k++) tick(1);
        chk("output_count", out_cnt, target);
    endtask

    task automatic run_mat(input int si, input int sj, input logic sg, input int base);
        int tgt;
        start_mat(8'(si), 8'(sj), sg);
        for (int i = 0; i < si; i++) begin
            for (int j = 0; j < sj; j++) begin
                tgt = out_cnt + 1;
                feed(base + i * sj + j, j == 0, j == sj - 1, (i == si - 1) && (j == sj - 1));
                wait_out(tgt);
            end
        end
    endtask

    initial begin
        vt[0]  = '{8'd100, 8'd7, 0, 8'd14, 8'd2, 10};
        vt[1]  = '{8'd10,  8'd3, 0, 8'd3,  8'd1, 10};
        vt[2]  = '{8'd20,  8'd3, 1, 8'd6,  8'd2, 10};
        vt[3]  = '{8'd30,  8'd3, 2, 8'd10, 8'd0, 10};
        vt[4]  = '{8'd40,  8'd3, 0, 8'd13, 8'd1, 10};
        vt[5]  = '{8'd50,  8'd3, 3, 8'd16, 8'd2, 10};
        vt[6]  = '{8'd60,  8'd3, 1, 8'd20, 8'd0, 10};
        vt[7]  = '{8'd200, 8'd9, 3, 8'd22, 8'd2, 10};
        vt[8]  = '{8'd77,  8'd5, 0, 8'd15, 8'd2, 10};
        vt[9]  = '{8'd55,  8'd0, 1, 8'hFF, 8'd55, 2};
        vt[10] = '{8'd9,   8'd2, 0, 8'd4,  8'd1, 10};
        vt[11] = '{8'd123, 8'd4, 0, 8'd30, 8'd3, 10};
        vt[12] = '{8'd250, 8'd16, 2, 8'd15, 8'd10, 10};
`ifdef MODEL_MATRIX_INTEGER_DIVIDER_SIGNED_EN
        vt[13] = '{8'hF9, 8'h02, 0, 8'hFD, 8'hFF, 11};
        vt[14] = '{8'h07, 8'hFE, 1, 8'hFD, 8'h01, 11};
        vt[15] = '{8'h80, 8'hFF, 0, 8'h80, 8'h00, 11};
`else
        vt[13] = '{8'hF9, 8'h02, 0, 8'd124, 8'd1, 10};
        vt[14] = '{8'h07, 8'hFE, 1, 8'h00, 8'h07, 10};
        vt[15] = '{8'h80, 8'hFF, 0, 8'h00, 8'h80, 10};
`endif
        vt[16] = '{8'hFF, 8'h01, 0, 8'hFF, 8'h00, 10};
        vt[17] = '{8'h03, 8'hFF, 2, 8'h00, 8'h03, 10};

        bus.START = 1'b0; bus.SIGNED_MODE = 1'b0;
        bus.DATA_A_IN_I_ENABLE = 1'b0; bus.DATA_A_IN_J_ENABLE = 1'b0;
        bus.DATA_B_IN_I_ENABLE = 1'b0; bus.DATA_B_IN_J_ENABLE = 1'b0;
        bus.SIZE_I_IN = '0; bus.SIZE_J_IN = '0; bus.DATA_A_IN = '0; bus.DATA_B_IN = '0;

        tick(3);
        @(negedge CLK);
        chk("rst_data_out", bus.DATA_OUT, 0);
        chk("rst_rest_out", bus.REST_OUT, 0);
        chk("rst_ready", bus.READY, 0);
        chk("rst_j_en", bus.DATA_OUT_J_ENABLE, 0);
        chk("rst_i_en", bus.DATA_OUT_I_ENABLE, 0);
        chk("rst_dbz", bus.DIV_BY_ZERO, 0);
        RST = 1'b1;
        tick(2);

        run_mat(1, 1, 1'b0, 0);
        run_mat(2, 3, 1'b0, 1);

        // A leads B by three cycles; a stray START during DIVIDE must be ignored.
        start_mat(8'd1, 8'd2, 1'b0);
        base_cnt = out_cnt;
        feed(7, 1'b1, 1'b0, 1'b0);
        tick(3);
        bus.SIZE_I_IN = 8'd1; bus.SIZE_J_IN = 8'd1;
        bus.START = 1'b1;
        tick(1);
        bus.START = 1'b0;
        wait_out(base_cnt + 1);
        feed(8, 1'b0, 1'b1, 1'b1);
        wait_out(base_cnt + 2);

        start_mat(8'd1, 8'd2, 1'b0);
        base_cnt = out_cnt;
        feed(9, 1'b1, 1'b0, 1'b0);
        wait_out(base_cnt + 1);
        @(negedge CLK);
        chk("dbz_set", bus.DIV_BY_ZERO, 1);
        tick(1);
        feed(10, 1'b0, 1'b1, 1'b1);
        wait_out(base_cnt + 2);
        @(negedge CLK);
        chk("dbz_sticky", bus.DIV_BY_ZERO, 1);
        tick(1);

        // Zero-sized matrices: READY pulse on the next cycle, no element enables.
        base_cnt = out_cnt;
        bus.SIZE_I_IN = 8'd0; bus.SIZE_J_IN = 8'd3; bus.START = 1'b1;
        tick(1);
        bus.START = 1'b0;
        @(negedge CLK);
        chk("zero_size_ready", bus.READY, 1);
        chk("zero_size_dbz_cleared", bus.DIV_BY_ZERO, 0);
        @(negedge CLK);
        chk("zero_size_ready_drop", bus.READY, 0);
        tick(1);
        bus.SIZE_I_IN = 8'd2; bus.SIZE_J_IN = 8'd0; bus.START = 1'b1;
        tick(1);
        bus.START = 1'b0;
        @(negedge CLK);
        chk("zero_j_ready", bus.READY, 1);
        tick(3);
        chk("zero_size_no_output", out_cnt, base_cnt);

        // Reset while dividing abandons the element.
        start_mat(8'd1, 8'd1, 1'b0);
        feed(11, 1'b1, 1'b1, 1'b1);
        tick(4);
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_data_out", bus.DATA_OUT, 0);
        chk("mid_rst_rest_out", bus.REST_OUT, 0);
        chk("mid_rst_j_en", bus.DATA_OUT_J_ENABLE, 0);
        sb.delete();
        tick(2);
        RST = 1'b1;
        base_cnt = out_cnt;
        tick(15);
        chk("mid_rst_no_output", out_cnt, base_cnt);

        run_mat(1, 1, 1'b0, 12);
        run_mat(1, 3, 1'b1, 13);
        run_mat(1, 2, 1'b0, 16);

        tick(3);
        chk("scoreboard_drained", sb.size(), 0);
        chk("ready_only_pulses", ready_only, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
